// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl
//   Multi-cycle instruction fetch stage. Holds the PC, issues one read per
//   instruction on an AXI-lite-style AR/R channel, hands the fetched word
//   (or a fault code) to the IDU over valid/ready, then waits for the next
//   PC from commit before fetching again.
//
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   araddr, arvalid, arready read-address channel (araddr always equals pc)
//   rdata, rresp, rvalid,
//   rready                   read-data channel
//   inst_valid, inst_ready,
//   inst, pc, fault          result to IDU (fault: 00 ok, 01 bus error,
//                            10 misaligned pc, 11 timeout)
//   npc_valid, npc           next PC from commit, accepted only in WAIT_NPC
//   busy                     high in every state except WAIT_NPC
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [1:0]  fault,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  output logic        busy
);

  localparam logic [1:0] S_ADDR     = 2'd0;
  localparam logic [1:0] S_WAIT_R   = 2'd1;
  localparam logic [1:0] S_OUT      = 2'd2;
  localparam logic [1:0] S_WAIT_NPC = 2'd3;

  localparam logic [1:0] F_NONE  = 2'b00;
  localparam logic [1:0] F_BUS   = 2'b01;
  localparam logic [1:0] F_ALIGN = 2'b10;
  localparam logic [1:0] F_TOUT  = 2'b11;

  localparam int                CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  assign araddr = pc;
  assign busy   = (state != S_WAIT_NPC);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_ADDR;
      pc         <= RESET_PC;
      cnt        <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= 32'h0;
      fault      <= F_NONE;
    end else begin
      case (state)
        S_ADDR: begin
          if (pc[1:0] != 2'b00) begin
            // Misaligned PC never touches the bus.
            arvalid    <= 1'b0;
            inst       <= 32'h0;
            fault      <= F_ALIGN;
            inst_valid <= 1'b1;
            state      <= S_OUT;
          end else if (!arvalid) begin
            // Only reached right after reset; entry from WAIT_NPC raises
            // arvalid on the same edge to keep the loop at 4 cycles.
            arvalid <= 1'b1;
          end else if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            cnt     <= '0;
            state   <= S_WAIT_R;
          end
        end
        S_WAIT_R: begin
          if (rvalid) begin
            rready     <= 1'b0;
            inst_valid <= 1'b1;
            state      <= S_OUT;
            if (rresp == 2'b00) begin
              inst  <= rdata;
              fault <= F_NONE;
            end else begin
              inst  <= 32'h0;
              fault <= F_BUS;
            end
          end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
            // Dropping rready abandons the read; a late rvalid is ignored.
            rready     <= 1'b0;
            inst_valid <= 1'b1;
            inst       <= 32'h0;
            fault      <= F_TOUT;
            state      <= S_OUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            state      <= S_WAIT_NPC;
          end
        end
        S_WAIT_NPC: begin
          if (npc_valid) begin
            pc      <= npc;
            arvalid <= (npc[1:0] == 2'b00);
            state   <= S_ADDR;
          end
        end
        default: state <= S_ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Self-checking bench for ifu_fetch_ctrl with a result scoreboard.
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [1:0]  fault;
  logic        npc_valid;
  logic [31:0] npc;
  logic        busy;

  ifu_fetch_ctrl #(.RESET_PC(32'h8000_0000), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .pc(pc), .fault(fault),
    .npc_valid(npc_valid), .npc(npc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  fault;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   hs_cnt = 0;

  always @(posedge clk) if (rst && arvalid && arready) hs_cnt <= hs_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards apply to the next edge and
  // outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_arvalid(input string tag);
    int k = 0;
    while (!arvalid && k < 10) begin
      tick();
      k++;
    end
    chk({tag, "_arvalid"}, 32'(arvalid), 32'd1);
  endtask

  task automatic wait_inst_valid(input string tag);
    int k = 0;
    while (!inst_valid && k < 10) begin
      tick();
      k++;
    end
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd1);
  endtask

  task automatic push_exp(input logic [31:0] i, input logic [31:0] p, input logic [1:0] f);
    exp_t e;
    e.inst = i; e.pc = p; e.fault = f;
    sb_q.push_back(e);
  endtask

  // IDU side: accept the presented result and score it.
  task automatic take_out(input string tag);
    exp_t e;
    inst_ready = 1'b1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_inst"},  inst,         e.inst);
      chk({tag, "_pc"},    pc,           e.pc);
      chk({tag, "_fault"}, 32'(fault),   32'(e.fault));
    end
    tick();
    inst_ready = 1'b0;
    chk({tag, "_ivalid_drop"}, 32'(inst_valid), 32'd0);
    chk({tag, "_busy_idle"},   32'(busy),       32'd0);
  endtask

  task automatic send_npc(input string tag, input logic [31:0] a);
    npc_valid = 1'b1;
    npc       = a;
    tick();
    npc_valid = 1'b0;
    chk({tag, "_pc_load"}, pc,          a);
    chk({tag, "_busy"},    32'(busy),   32'd1);
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input int ar_stall,
                       input int r_delay, input logic [31:0] d, input logic [1:0] resp,
                       input int rdy_stall, input logic [31:0] exp_inst,
                       input logic [1:0] exp_fault);
    logic [31:0] c_inst, c_pc;
    logic [1:0]  c_fault;
    int          hs0;
    wait_arvalid(tag);
    chk({tag, "_araddr"}, araddr, addr);
    hs0 = hs_cnt;
    for (int i = 0; i < ar_stall; i++) begin
      tick();
      chk({tag, "_ar_hold"},  32'(arvalid), 32'd1);
      chk({tag, "_ar_addr"},  araddr,       addr);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk({tag, "_ar_hs_once"}, 32'(hs_cnt - hs0), 32'd1);
    chk({tag, "_ar_drop"},    32'(arvalid),      32'd0);
    chk({tag, "_rready"},     32'(rready),       32'd1);
    for (int i = 0; i < r_delay; i++) tick();
    rvalid = 1'b1; rdata = d; rresp = resp;
    push_exp(exp_inst, addr, exp_fault);
    tick();
    rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    wait_inst_valid(tag);
    chk({tag, "_rready_off"}, 32'(rready), 32'd0);
    c_inst = inst; c_pc = pc; c_fault = fault;
    for (int i = 0; i < rdy_stall; i++) begin
      npc_valid = 1'b1;            // must be ignored outside WAIT_NPC
      npc       = 32'h1234_5678;
      tick();
      npc_valid = 1'b0;
      chk({tag, "_stall_valid"}, 32'(inst_valid), 32'd1);
      chk({tag, "_stall_inst"},  inst,            c_inst);
      chk({tag, "_stall_pc"},    pc,              c_pc);
      chk({tag, "_stall_fault"}, 32'(fault),      32'(c_fault));
    end
    take_out(tag);
  endtask

  initial begin
    int k;
    rst = 1'b0; arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0;
    inst_ready = 1'b0; npc_valid = 1'b0; npc = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst_arvalid", 32'(arvalid),    32'd0);
    chk("rst_rready",  32'(rready),     32'd0);
    chk("rst_ivalid",  32'(inst_valid), 32'd0);
    chk("rst_inst",    inst,            32'h0);
    chk("rst_fault",   32'(fault),      32'd0);
    chk("rst_pc",      pc,              32'h8000_0000);
    chk("rst_busy",    32'(busy),       32'd1);
    rst = 1'b1;
    tick();
    chk("rel_arvalid_1cyc", 32'(arvalid), 32'd1);

    // Basic fetch
    fetch("t1", 32'h8000_0000, 0, 0, 32'h0000_0413, 2'b00, 0, 32'h0000_0413, 2'b00);
    send_npc("t1n", 32'h8000_0004);
    chk("npc_arvalid_1cyc", 32'(arvalid), 32'd1);

    // arready stalled 5 cycles
    fetch("t2", 32'h8000_0004, 5, 0, 32'h0010_0093, 2'b00, 0, 32'h0010_0093, 2'b00);
    send_npc("t2n", 32'h8000_0008);

    // Bus error response, rvalid delayed
    fetch("t3", 32'h8000_0008, 0, 2, 32'hdead_beef, 2'b10, 0, 32'h0, 2'b01);
    send_npc("t3n", 32'h8000_0006);

    // Misaligned PC
    chk("t4_no_arvalid", 32'(arvalid), 32'd0);
    tick();
    chk("t4_no_arvalid2", 32'(arvalid),    32'd0);
    chk("t4_ivalid",      32'(inst_valid), 32'd1);
    push_exp(32'h0, 32'h8000_0006, 2'b10);
    take_out("t4");
    send_npc("t4n", 32'h8000_000C);

    // Timeout
    wait_arvalid("t5");
    arready = 1'b1;
    push_exp(32'h0, 32'h8000_000C, 2'b11);
    tick();
    arready = 1'b0;
    k = 0;
    while (!inst_valid && k < 20) begin
      tick();
      k++;
    end
    chk("t5_tout_cycles", 32'(k),      32'd8);
    chk("t5_fault",       32'(fault),  32'd3);
    rvalid = 1'b1; rdata = 32'h1111_2222;
    tick();
    rvalid = 1'b0;
    chk("t5_late_rready", 32'(rready), 32'd0);
    chk("t5_late_inst",   inst,        32'h0);
    take_out("t5");

    // PC wrap region, with stalls on both channels and on inst_ready
    send_npc("t6n", 32'hFFFF_FFFC);
    fetch("t6", 32'hFFFF_FFFC, 1, 1, 32'hcafe_f00d, 2'b00, 3, 32'hcafe_f00d, 2'b00);
    send_npc("t7n", 32'h8000_0004);

    // Reset while waiting for read data
    wait_arvalid("t7");
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("t7_in_wait_r", 32'(rready), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t7_rst_arvalid", 32'(arvalid),    32'd0);
    chk("t7_rst_rready",  32'(rready),     32'd0);
    chk("t7_rst_ivalid",  32'(inst_valid), 32'd0);
    rvalid = 1'b1; rdata = 32'h5555_5555;   // stale response from dropped read
    tick();
    rvalid = 1'b0;
    chk("t7_reissue",      32'(arvalid),    32'd1);
    chk("t7_reissue_addr", araddr,          32'h8000_0000);
    chk("t7_stale_ignored",32'(inst_valid), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
